// File: rtl/seq_restoring_divider_if.sv
// rtl/seq_restoring_divider_if.sv - operand/result handshake bundle for the sequential divider
interface seq_restoring_divider_if #(
    parameter int N = 8
) ();
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - iterative restoring divider, one trial subtraction per cycle
// Optional DIV_SIGNED_EN: two's complement operands with a one-cycle sign fix-up after the unsigned core.
module seq_restoring_divider #(
    parameter int N = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seq_restoring_divider_if.slave div
);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t        state;
    logic [N-1:0]  rem_q;
    logic [N-1:0]  dq;
    logic [N-1:0]  b_q;
    logic [CW-1:0] cnt;

    logic [N:0]    partial;
    logic [N:0]    diff;
    logic          q_bit;
    logic [N-1:0]  rem_next;
    logic [N-1:0]  dq_next;
    logic [N-1:0]  a_mag;
    logic [N-1:0]  b_mag;

`ifdef DIV_SIGNED_EN
    logic          neg_q;
    logic          neg_r;
`endif

    // dq starts as the dividend and shifts left; quotient bits fill in from the LSB end
    always_comb begin
        partial  = {rem_q, dq[N-1]};
        diff     = partial - {1'b0, b_q};
        q_bit    = ~diff[N];
        rem_next = q_bit ? diff[N-1:0] : partial[N-1:0];
        dq_next  = {dq[N-2:0], q_bit};
`ifdef DIV_SIGNED_EN
        a_mag    = div.dividend[N-1] ? -div.dividend : div.dividend;
        b_mag    = div.divisor[N-1]  ? -div.divisor  : div.divisor;
`else
        a_mag    = div.dividend;
        b_mag    = div.divisor;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            div.in_ready    <= 1'b1;
            div.out_valid   <= 1'b0;
            div.quotient    <= '0;
            div.remainder   <= '0;
            div.div_by_zero <= 1'b0;
            rem_q           <= '0;
            dq              <= '0;
            b_q             <= '0;
            cnt             <= '0;
`ifdef DIV_SIGNED_EN
            neg_q           <= 1'b0;
            neg_r           <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (div.in_valid && div.in_ready) begin
                        div.in_ready <= 1'b0;
                        if (div.divisor == '0) begin
                            state           <= DONE;
                            div.out_valid   <= 1'b1;
                            div.quotient    <= '1;
                            div.remainder   <= div.dividend;
                            div.div_by_zero <= 1'b1;
                        end else begin
                            state <= CALC;
                            rem_q <= '0;
                            dq    <= a_mag;
                            b_q   <= b_mag;
                            cnt   <= '0;
`ifdef DIV_SIGNED_EN
                            neg_q <= div.dividend[N-1] ^ div.divisor[N-1];
                            neg_r <= div.dividend[N-1];
`endif
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_next;
                    dq    <= dq_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
`ifdef DIV_SIGNED_EN
                        state <= FIX;
`else
                        state           <= DONE;
                        div.out_valid   <= 1'b1;
                        div.quotient    <= dq_next;
                        div.remainder   <= rem_next;
                        div.div_by_zero <= 1'b0;
`endif
                    end
                end
`ifdef DIV_SIGNED_EN
                // -2^(N-1) / -1 wraps back to -2^(N-1) through the magnitude path
                FIX: begin
                    state           <= DONE;
                    div.out_valid   <= 1'b1;
                    div.quotient    <= neg_q ? -dq : dq;
                    div.remainder   <= neg_r ? -rem_q : rem_q;
                    div.div_by_zero <= 1'b0;
                end
`endif
                DONE: begin
                    if (div.out_ready) begin
                        state         <= IDLE;
                        div.out_valid <= 1'b0;
                        div.in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - directed self-checking bench for seq_restoring_divider
module tb_seq_restoring_divider;
    localparam int N = 8;
`ifdef DIV_SIGNED_EN
    localparam int LAT = N + 2;
`else
    localparam int LAT = N + 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    seq_restoring_divider_if #(.N(N)) io ();

    seq_restoring_divider #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .div   (io.slave)
    );

    always #5 clk = ~clk;

    task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge clk);
        io.in_valid = 1'b1;
        io.dividend = a;
        io.divisor  = b;
        @(posedge clk);
        @(negedge clk);
        io.in_valid = 1'b0;
    endtask

    task automatic wait_result(input int start, output int cyc);
        cyc = start;
        while (!io.out_valid && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic pop;
        io.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        io.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", io.in_ready); end
        checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", io.out_valid); end
        checks++; if (io.quotient !== 8'd0) begin errors++; $display("FAIL reset_quotient got %0d want 0", io.quotient); end
        checks++; if (io.remainder !== 8'd0) begin errors++; $display("FAIL reset_remainder got %0d want 0", io.remainder); end
        checks++; if (io.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b want 0", io.div_by_zero); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_hold;
        int cyc;
        start_op(8'd100, 8'd7);
        wait_result(1, cyc);
        checks++; if (cyc != LAT) begin errors++; $display("FAIL basic_latency got %0d want %0d", cyc, LAT); end
        checks++; if (io.quotient !== 8'd14) begin errors++; $display("FAIL basic_quotient got %0d want 14", io.quotient); end
        checks++; if (io.remainder !== 8'd2) begin errors++; $display("FAIL basic_remainder got %0d want 2", io.remainder); end
        checks++; if (io.div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_dbz got %b want 0", io.div_by_zero); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (io.out_valid !== 1'b1 || io.quotient !== 8'd14 || io.remainder !== 8'd2) begin
                errors++;
                $display("FAIL hold_%0d got v=%b q=%0d r=%0d want v=1 q=14 r=2", i, io.out_valid, io.quotient, io.remainder);
            end
        end
        pop();
        checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL drop_out_valid got %b want 0", io.out_valid); end
        checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %b want 1", io.in_ready); end
        checks++; if (io.quotient !== 8'd14) begin errors++; $display("FAIL keep_quotient got %0d want 14", io.quotient); end
    endtask

    task automatic test_div_zero;
        int cyc;
        start_op(8'd255, 8'd0);
        wait_result(1, cyc);
        checks++; if (cyc != 1) begin errors++; $display("FAIL dz_latency got %0d want 1", cyc); end
        checks++; if (io.quotient !== 8'd255) begin errors++; $display("FAIL dz_quotient got %0d want 255", io.quotient); end
        checks++; if (io.remainder !== 8'd255) begin errors++; $display("FAIL dz_remainder got %0d want 255", io.remainder); end
        checks++; if (io.div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag got %b want 1", io.div_by_zero); end
        pop();
    endtask

    task automatic test_boundaries;
        int cyc;
        start_op(8'd5, 8'd9);
        wait_result(1, cyc);
        checks++; if (io.quotient !== 8'd0) begin errors++; $display("FAIL small_quotient got %0d want 0", io.quotient); end
        checks++; if (io.remainder !== 8'd5) begin errors++; $display("FAIL small_remainder got %0d want 5", io.remainder); end
        pop();
        // competing operands offered mid-calculation must not disturb the running op
        start_op(8'd200, 8'd1);
        io.in_valid = 1'b1;
        io.dividend = 8'd3;
        io.divisor  = 8'd3;
        repeat (2) @(negedge clk);
        checks++; if (io.in_ready !== 1'b0) begin errors++; $display("FAIL calc_in_ready got %b want 0", io.in_ready); end
        wait_result(3, cyc);
        io.in_valid = 1'b0;
        checks++; if (cyc != LAT) begin errors++; $display("FAIL one_latency got %0d want %0d", cyc, LAT); end
        checks++; if (io.quotient !== 8'd200) begin errors++; $display("FAIL one_quotient got %0d want 200", io.quotient); end
        checks++; if (io.remainder !== 8'd0) begin errors++; $display("FAIL one_remainder got %0d want 0", io.remainder); end
        pop();
    endtask

    task automatic test_reset_abort;
        int cyc;
        start_op(8'd100, 8'd7);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (io.out_valid !== 1'b0 || io.quotient !== 8'd0 || io.remainder !== 8'd0) begin
            errors++;
            $display("FAIL abort_outputs got v=%b q=%0d r=%0d want 0 0 0", io.out_valid, io.quotient, io.remainder);
        end
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL abort_no_result got %b want 0", io.out_valid); end
        start_op(8'd60, 8'd6);
        wait_result(1, cyc);
        checks++; if (cyc != LAT) begin errors++; $display("FAIL after_abort_latency got %0d want %0d", cyc, LAT); end
        checks++; if (io.quotient !== 8'd10) begin errors++; $display("FAIL after_abort_quotient got %0d want 10", io.quotient); end
        checks++; if (io.remainder !== 8'd0) begin errors++; $display("FAIL after_abort_remainder got %0d want 0", io.remainder); end
        pop();
    endtask

    task automatic test_back_to_back;
        int cyc;
        io.out_ready = 1'b1;
        start_op(8'd50, 8'd5);
        wait_result(1, cyc);
        checks++; if (io.quotient !== 8'd10 || cyc != LAT) begin errors++; $display("FAIL b2b_first got q=%0d cyc=%0d want q=10 cyc=%0d", io.quotient, cyc, LAT); end
        @(negedge clk);
        checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drop got %b want 0", io.out_valid); end
        start_op(8'd17, 8'd4);
        wait_result(1, cyc);
        checks++; if (io.quotient !== 8'd4 || io.remainder !== 8'd1) begin errors++; $display("FAIL b2b_second got q=%0d r=%0d want q=4 r=1", io.quotient, io.remainder); end
        io.out_ready = 1'b0;
        pop();
    endtask

`ifdef DIV_SIGNED_EN
    task automatic test_signed;
        int cyc;
        start_op(8'hF9, 8'd2);
        wait_result(1, cyc);
        checks++; if (cyc != N + 2) begin errors++; $display("FAIL sgn_latency got %0d want %0d", cyc, N + 2); end
        checks++; if (io.quotient !== 8'hFD || io.remainder !== 8'hFF) begin errors++; $display("FAIL sgn_m7_2 got q=%h r=%h want q=fd r=ff", io.quotient, io.remainder); end
        pop();
        start_op(8'h80, 8'hFF);
        wait_result(1, cyc);
        checks++; if (io.quotient !== 8'h80 || io.remainder !== 8'h00) begin errors++; $display("FAIL sgn_overflow got q=%h r=%h want q=80 r=00", io.quotient, io.remainder); end
        pop();
        start_op(8'h07, 8'hFE);
        wait_result(1, cyc);
        checks++; if (io.quotient !== 8'hFD || io.remainder !== 8'h01) begin errors++; $display("FAIL sgn_7_m2 got q=%h r=%h want q=fd r=01", io.quotient, io.remainder); end
        pop();
    endtask
`endif

    initial begin
        io.in_valid  = 1'b0;
        io.dividend  = '0;
        io.divisor   = '0;
        io.out_ready = 1'b0;
        test_reset();
        test_basic_hold();
        test_div_zero();
        test_boundaries();
        test_reset_abort();
        test_back_to_back();
`ifdef DIV_SIGNED_EN
        test_signed();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
